pifo_push_arbiter: RTL
======================

PIFO_PUSH_ARBITER -- requirements
Module: pifo_push_arbiter

Interface
REQ-001 Parameter PORTS, default 4: number of ingress requesters, range 2..16.
REQ-002 Parameter FLOWS, default 10: one-hot flow width, equal to the attached PIFO's FLOWS.
REQ-003 Parameter CAPACITY, default 50: maximum entries outstanding in the attached PIFO, range 1..2^16-1.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 req_valid  in  PORTS  per-port push request.
REQ-007 req_rank  in  PORTS x 32  per-port rank.
REQ-008 req_value  in  PORTS x 32  per-port value.
REQ-009 req_flow  in  PORTS x FLOWS  per-port one-hot flow.
REQ-010 req_ready  out  PORTS  per-port accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-011 push / push_rank / push_value / push_flow  out  1 / 32 / 32 / FLOWS  registered push to the PIFO.
REQ-012 deq_pop  in  1  consumer pop request.
REQ-013 pop  out  1  pop to the PIFO, equal to deq_pop combinationally.
REQ-014 pop_valid / pop_value  in  1 / 32  PIFO pop result.
REQ-015 deq_valid / deq_value  out  1 / 32  pop_valid and pop_value passed through combinationally.
REQ-016 occupancy  out  clog2(CAPACITY+1)  registered count of accepted, not-yet-popped entries.
REQ-017 err_drop  out  1  registered one-cycle pulse for a discarded malformed request.
REQ-018 grant_count  out  PORTS x 32  per-port accepted-transfer counters (see Configuration).

Function
REQ-019 space = (occupancy < CAPACITY); with space low, all req_ready bits shall be 0.
REQ-020 With space high, exactly one req_ready bit shall be high: the first valid port searched from (rr_ptr+1) mod PORTS upward with wrap; if no port is valid, all bits shall be 0.
REQ-021 req_ready shall be combinational from req_valid, rr_ptr and occupancy; it shall not depend on deq_pop or pop_valid.
REQ-022 On any transfer, rr_ptr shall load the granted index; otherwise rr_ptr holds.
REQ-023 A transfer with one-hot req_flow shall, one cycle later, drive push=1 with that port's rank, value and flow; push=0 otherwise, with the rank, value and flow outputs holding their last values.
REQ-024 A transfer with zero or multiple-hot req_flow shall be accepted and discarded: no push, no occupancy change, err_drop=1 for the next cycle only.
REQ-025 Occupancy shall increment on a forwarded transfer (counted at acceptance, including the in-flight cycle) and decrement on pop && pop_valid.
REQ-026 Simultaneous increment and decrement shall leave occupancy unchanged.
REQ-027 A decrement with occupancy 0 shall saturate at 0; occupancy shall never exceed CAPACITY.
REQ-028 Maximum throughput shall be one transfer per cycle; grant-to-push latency shall be exactly 1 cycle.

Reset
REQ-029 While rst is high at a clock edge: push=0, err_drop=0, occupancy=0, rr_ptr=PORTS-1 (port 0 wins first), grant_count all 0; push_rank, push_value and push_flow shall be 0.
REQ-030 A transfer presented in the reset cycle shall be lost; no push shall follow it.
REQ-031 req_ready shall be all 0 during a reset cycle.

Configuration
REQ-032 Macro PIFO_ARB_GRANT_STATS_EN defined: grant_count[i] shall increment, wrapping at 2^32, on every transfer from port i, including discarded ones.
REQ-033 Macro PIFO_ARB_GRANT_STATS_EN undefined: grant_count shall be tied to 0 and no counter registers shall be built; all other behaviour is identical.

Verification
REQ-034 All 4 ports valid continuously, CAPACITY large, no pops -> grants 0,1,2,3,0,... on consecutive cycles; push seen one cycle after each grant.
REQ-035 CAPACITY=2, ports 0 and 1 valid, no pops -> two transfers, occupancy=2, req_ready all 0 after that; one pop && pop_valid -> occupancy 1 and the next grant goes to the rotating port.
REQ-036 Transfer and pop && pop_valid in the same cycle at occupancy 1 -> occupancy stays 1.
REQ-037 Port 2 alone with req_flow=0b0000000011 -> req_ready[2]=1, no push, err_drop=1 for one cycle, occupancy unchanged.
REQ-038 rst asserted for one cycle mid-stream with port 1 valid -> push=0 and occupancy=0 in the following cycle; next grant goes to port 0 if valid.
REQ-039 With PIFO_ARB_GRANT_STATS_EN defined, 5 transfers from port 3 -> grant_count[3]=5 and other ports 0; with it undefined -> all 0.

Source files
------------

// File: rtl/pifo_push_arbiter.sv
// Round-robin ingress arbiter in front of a PIFO: one registered push per cycle, occupancy tracking, malformed-flow drop.
// Optional per-port grant counters are built when PIFO_ARB_GRANT_STATS_EN is defined.
module pifo_push_arbiter #(
    parameter int PORTS    = 4,
    parameter int FLOWS    = 10,
    parameter int CAPACITY = 50
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [PORTS-1:0]                   req_valid,
    input  logic [PORTS-1:0][31:0]             req_rank,
    input  logic [PORTS-1:0][31:0]             req_value,
    input  logic [PORTS-1:0][FLOWS-1:0]        req_flow,
    output logic [PORTS-1:0]                   req_ready,
    output logic                               push,
    output logic [31:0]                        push_rank,
    output logic [31:0]                        push_value,
    output logic [FLOWS-1:0]                   push_flow,
    input  logic                               deq_pop,
    output logic                               pop,
    input  logic                               pop_valid,
    input  logic [31:0]                        pop_value,
    output logic                               deq_valid,
    output logic [31:0]                        deq_value,
    output logic [$clog2(CAPACITY+1)-1:0]      occupancy,
    output logic                               err_drop,
    output logic [PORTS-1:0][31:0]             grant_count
);

    localparam int OCC_W = $clog2(CAPACITY + 1);
    localparam int PTR_W = $clog2(PORTS);

    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] cand;
    logic [PTR_W-1:0] gnt_idx;
    logic             gnt_hit;
    logic             space;
    logic             xfer;
    logic             flow_ok;
    logic             inc;
    logic             dec;

    assign pop       = deq_pop;
    assign deq_valid = pop_valid;
    assign deq_value = pop_value;

    assign space = (occupancy < OCC_W'(CAPACITY));

    // Search starts one past the last winner so every port gets a turn.
    always_comb begin
        cand      = '0;
        gnt_idx   = rr_ptr;
        gnt_hit   = 1'b0;
        req_ready = '0;
        for (int i = 1; i <= PORTS; i++) begin
            cand = PTR_W'((int'(rr_ptr) + i) % PORTS);
            if (!gnt_hit && req_valid[cand]) begin
                gnt_hit = 1'b1;
                gnt_idx = cand;
            end
        end
        xfer = gnt_hit && space && !rst;
        if (xfer) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign flow_ok = $onehot(req_flow[gnt_idx]);
    assign inc     = xfer && flow_ok;
    // Popping an empty PIFO must not wrap the count.
    assign dec     = pop && pop_valid && (occupancy != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr     <= PTR_W'(PORTS - 1);
            push       <= 1'b0;
            push_rank  <= '0;
            push_value <= '0;
            push_flow  <= '0;
            err_drop   <= 1'b0;
            occupancy  <= '0;
        end else begin
            push     <= inc;
            err_drop <= xfer && !flow_ok;
            if (xfer) begin
                rr_ptr <= gnt_idx;
            end
            if (inc) begin
                push_rank  <= req_rank[gnt_idx];
                push_value <= req_value[gnt_idx];
                push_flow  <= req_flow[gnt_idx];
            end
            if (inc && !dec) begin
                occupancy <= occupancy + OCC_W'(1);
            end else if (dec && !inc) begin
                occupancy <= occupancy - OCC_W'(1);
            end
        end
    end

`ifdef PIFO_ARB_GRANT_STATS_EN
    logic [PORTS-1:0][31:0] grant_cnt_q;

    // Counts every accepted transfer, dropped ones included.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt_q <= '0;
        end else if (xfer) begin
            grant_cnt_q[gnt_idx] <= grant_cnt_q[gnt_idx] + 32'd1;
        end
    end

    assign grant_count = grant_cnt_q;
`else
    assign grant_count = '0;
`endif

endmodule
